// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational ALU between two requesters. Requests are
//            arbitrated one at a time, and each result goes back over a
//            valid/ready handshake.
// Options  : ALU_ARB_FIXED_PRIO_EN - requester 0 always wins ties
//            (default build: round-robin arbitration)
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_apsr,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_grant;       // requester owning the op in flight
    logic   w_grant;       // requester that would win this cycle
    logic   w_accept;
    logic   w_rsp_taken;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 1 only wins when requester 0 has nothing pending.
    always_comb begin
        w_grant = ~req0_valid;
    end
`else
    logic r_last_grant;

    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = ~req0_valid;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    assign w_accept    = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready  = w_accept && !w_grant;
    assign req1_ready  = w_accept &&  w_grant;
    assign w_rsp_taken = r_grant ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_RESP;
            S_RESP:  if (w_rsp_taken) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            r_grant <= 1'b0;
        end else if (w_accept) begin
            alu_a   <= w_grant ? req1_a  : req0_a;
            alu_b   <= w_grant ? req1_b  : req0_b;
            alu_op  <= w_grant ? req1_op : req0_op;
            r_grant <= w_grant;
        end
    end

    // The ALU has had the whole ISSUE cycle to settle on the latched operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else if (r_state == S_ISSUE) begin
            rsp_data  <= alu_out;
            rsp_flags <= alu_apsr;
        end
    end

    assign rsp0_valid = (r_state == S_RESP) && !r_grant;
    assign rsp1_valid = (r_state == S_RESP) &&  r_grant;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// Bench for alu_share_arbiter: a transaction-level model checks every cycle,
// and directed scenarios pin the model against hand-computed values.
module tb_alu_share_arbiter;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 32;
    localparam int OP_W   = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OP_W-1:0] req0_op, req1_op;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp_data, alu_a, alu_b, alu_out;
    logic [FLAG_W-1:0] rsp_flags, alu_apsr;
    logic [OP_W-1:0] alu_op;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_apsr(alu_apsr),
        .busy(busy)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            default: return a + b + {28'd0, op};
        endcase
    endfunction

    // N, Z, C (of a+b), V (of a+b), opcode folded into the low bits.
    function automatic logic [31:0] flags_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        logic [32:0] s;
        r = alu_fn(a, b, op);
        s = {1'b0, a} + {1'b0, b};
        return {r[31], (r == 32'd0), s[32], (a[31] == b[31]) && (s[31] != a[31]), 28'd0} ^ {28'd0, op};
    endfunction

    assign alu_out  = alu_fn(alu_a, alu_b, alu_op);
    assign alu_apsr = flags_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, response two cycles after accept.
    bit          m_busy = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    int          m_acc = 0;
    logic [31:0] m_data, m_flags;
    bit          e_r0, e_r1, e_v0, e_v1, e_g;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else begin
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            e_g  = 1'b0;
            if (!m_busy && (req0_valid || req1_valid)) begin
                if (req0_valid && req1_valid) e_g = FIXED ? 1'b0 : (m_last == 1'b0);
                else                           e_g = !req0_valid;
                if (e_g) e_r1 = 1'b1; else e_r0 = 1'b1;
            end
            e_v0 = m_busy && (cyc >= m_acc + 2) && !m_owner;
            e_v1 = m_busy && (cyc >= m_acc + 2) &&  m_owner;
            chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
            chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
            chk("m_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e_v0});
            chk("m_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e_v1});
            chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
            if (e_v0 || e_v1) begin
                chk("m_rsp_data", rsp_data, m_data);
                chk("m_rsp_flags", rsp_flags, m_flags);
            end
            if (e_r0 || e_r1) begin
                m_busy  = 1'b1;
                m_owner = e_g;
                m_acc   = cyc;
                m_last  = e_g;
                m_data  = e_g ? alu_fn(req1_a, req1_b, req1_op) : alu_fn(req0_a, req0_b, req0_op);
                m_flags = e_g ? flags_fn(req1_a, req1_b, req1_op) : flags_fn(req0_a, req0_b, req0_op);
            end else if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
                m_busy = 1'b0;
            end
        end
    end

    // Handshake capture for the random requesters.
    bit s_r0, s_r1;
    always @(negedge clk) begin
        s_r0 = req0_ready;
        s_r1 = req1_ready;
    end

    task automatic clear_inputs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) begin g = 0; break; end
            if (req1_ready) begin g = 1; break; end
        end
        if (g < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout actual=none required=grant within 20 cycles");
        end
    endtask

    int g;
    int exp_order [4];
    logic [31:0] sampled_apsr;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags", rsp_flags, 32'd0);
        rst_n = 1'b1;

        // Single request: 0x0A + 0x02.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 32'h0A; req0_b = 32'h02; req0_op = 4'h0;
        rsp0_ready = 1; rsp1_ready = 1;
        @(negedge clk);
        chk("A_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("A_rsp0_early", {31'd0, rsp0_valid}, 32'd0);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        chk("A_busy_issue", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("A_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("A_rsp_data", rsp_data, 32'h0000_000C);
        chk("A_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        @(posedge clk); #1;

        // Both valid from reset.
        do_reset();
        exp_order = FIXED ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
        req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'h0;
        req1_valid = 1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 4'h0;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            chk($sformatf("B_grant%0d", k), g, exp_order[k]);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("B_rsp_data%0d", k), rsp_data, (g == 1) ? 32'd4 : 32'd2);
            chk($sformatf("B_rsp_valid%0d", k), {30'd0, rsp1_valid, rsp0_valid}, (g == 1) ? 32'd2 : 32'd1);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;

        // Stalled response: requester 1 must not be granted meanwhile.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 32'd5;  req0_b = 32'd7; req0_op = 4'h0;
        req1_valid = 1; req1_a = 32'd20; req1_b = 32'd3; req1_op = 4'h0;
        rsp0_ready = 0; rsp1_ready = 0;
        wait_grant(g);
        chk("C_grant", g, 32'd0);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("C_rsp0_hold", {31'd0, rsp0_valid}, 32'd1);
            chk("C_data_hold", rsp_data, 32'h0000_000C);
            chk("C_req1_ready", {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp0_ready = 1;
        wait_grant(g);
        chk("C_grant_req1", g, 32'd1);
        @(posedge clk); #1;
        req1_valid = 0; rsp1_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("C_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("C_rsp1_data", rsp_data, 32'h0000_0017);
        @(posedge clk); #1;

        // All-ones operands.
        req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_op = 4'h0;
        rsp0_ready = 1;
        wait_grant(g);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        sampled_apsr = alu_apsr;
        @(negedge clk);
        chk("D_rsp_data", rsp_data, 32'hFFFF_FFFE);
        chk("D_rsp_flags_vs_issue", rsp_flags, sampled_apsr);
        chk("D_rsp_flags", rsp_flags, 32'hA000_0000);
        @(posedge clk); #1;

        // Reset during ISSUE discards the op.
        req0_valid = 1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'h0;
        wait_grant(g);
        @(posedge clk); #1 req0_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("E_busy", {31'd0, busy}, 32'd0);
        chk("E_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("E_alu_a", alu_a, 32'd0);
        chk("E_alu_b", alu_b, 32'd0);
        chk("E_rsp_data", rsp_data, 32'd0);
        chk("E_rsp_flags", rsp_flags, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("E_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        // Random traffic against the model.
        for (int t = 0; t < 600; t++) begin
            @(posedge clk); #1;
            if (s_r0) req0_valid = 0;
            if (s_r1) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 15));
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 15));
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        if (s_r0) req0_valid = 0;
        if (s_r1) req1_valid = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (12) @(posedge clk);
        #1;
        req0_valid = 0; req1_valid = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("end_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
